// File: rtl/async_fifo_param.sv
// Dual-clock FIFO: Gray-coded pointers cross domains through SYNC_STAGES-deep
// synchronisers; registered full/empty, levels, almost flags and sticky errors.
module async_fifo_param #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_THRESH   = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  rd_clk,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Storage: written on wr_clk, read on rd_clk (dual-port, not reset)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d, waf_q, waf_d, wovf_q, wovf_d;
  logic [PW-1:0] rgray_sync_q [SYNC_STAGES];
  logic [PW-1:0] rgray_sync_d [SYNC_STAGES];
  logic [PW-1:0] rgray_w_c, rbin_w_c;
  logic          wr_push_c;

  // ---------------- read domain -----------------
  logic [PW-1:0]         rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d;
  logic                  rempty_q, rempty_d, rae_q, rae_d, rudf_q, rudf_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [PW-1:0]         wgray_sync_q [SYNC_STAGES];
  logic [PW-1:0]         wgray_sync_d [SYNC_STAGES];
  logic [PW-1:0]         wgray_r_c, wbin_r_c;
  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic                  rd_rst_c, rd_pop_c;

  assign rgray_w_c = rgray_sync_q[SYNC_STAGES-1];
  assign wgray_r_c = wgray_sync_q[SYNC_STAGES-1];
  assign rd_rst_c  = rst_sync_q[SYNC_STAGES-1];

  // Read-pointer synchroniser shift into the write domain
  always_comb begin
    rgray_sync_d[0] = rgray_q;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      rgray_sync_d[i] = rgray_sync_q[i-1];
    end
  end

  // Write-side next state: pointer advance, full, level and error flags
  always_comb begin
    wr_push_c = wr_en && !wfull_q;
    wbin_d    = wbin_q + PW'(wr_push_c);
    wgray_d   = bin2gray(wbin_d);
    rbin_w_c  = gray2bin(rgray_w_c);
    wfull_d   = (wgray_d == {~rgray_w_c[PW-1:PW-2], rgray_w_c[PW-3:0]});
    wlevel_d  = wbin_d - rbin_w_c;
    waf_d     = (wlevel_d >= PW'(AF_THRESH));
    wovf_d    = wovf_q | (wr_en && wfull_q);
  end

  // Write-side registers with synchronous reset
  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wbin_q       <= '0;
      wgray_q      <= '0;
      wlevel_q     <= '0;
      wfull_q      <= 1'b0;
      waf_q        <= 1'b0;
      wovf_q       <= 1'b0;
      rgray_sync_q <= '{default: '0};
    end else begin
      wbin_q       <= wbin_d;
      wgray_q      <= wgray_d;
      wlevel_q     <= wlevel_d;
      wfull_q      <= wfull_d;
      waf_q        <= waf_d;
      wovf_q       <= wovf_d;
      rgray_sync_q <= rgray_sync_d;
    end
  end

  // Memory write port; writes during reset are discarded
  always_ff @(posedge wr_clk) begin
    if (!reset && wr_push_c) begin
      mem_q[wbin_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Reset synchroniser and write-pointer synchroniser shift into read domain
  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], reset};
    wgray_sync_d[0] = wgray_q;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      wgray_sync_d[i] = wgray_sync_q[i-1];
    end
  end

  // Read-domain reset chain (free-running, carries reset across)
  always_ff @(posedge rd_clk) begin
    rst_sync_q <= rst_sync_d;
  end

  // Read-side next state: pop, empty, level, data and error flags
  always_comb begin
    rd_pop_c = rd_en && !rempty_q;
    rbin_d   = rbin_q + PW'(rd_pop_c);
    rgray_d  = bin2gray(rbin_d);
    wbin_r_c = gray2bin(wgray_r_c);
    rempty_d = (rgray_d == wgray_r_c);
    rlevel_d = wbin_r_c - rbin_d;
    rae_d    = (rlevel_d <= PW'(AE_THRESH));
    rvalid_d = rd_pop_c;
    rudf_d   = rudf_q | (rd_en && rempty_q);
    rdata_d  = rdata_q;
    if (rd_pop_c) begin
      rdata_d = mem_q[rbin_q[ADDR_WIDTH-1:0]];
    end
  end

  // Read-side registers, reset by the synchronised rd_rst
  always_ff @(posedge rd_clk) begin
    if (rd_rst_c) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      rae_q        <= 1'b1;
      rudf_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      wgray_sync_q <= '{default: '0};
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      rae_q        <= rae_d;
      rudf_q       <= rudf_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      wgray_sync_q <= wgray_sync_d;
    end
  end

  assign wr_full         = wfull_q;
  assign wr_almost_full  = waf_q;
  assign wr_level        = wlevel_q;
  assign wr_overflow     = wovf_q;
  assign rd_data         = rdata_q;
  assign rd_valid        = rvalid_q;
  assign rd_empty        = rempty_q;
  assign rd_almost_empty = rae_q;
  assign rd_level        = rlevel_q;
  assign rd_underflow    = rudf_q;

endmodule

// File: tb/tb_async_fifo_param.sv
// Scoreboard bench for async_fifo_param: directed checks on a default 8x8
// instance and randomized traffic on a 16x16 instance at 3:1 and 1:3 ratios.
module tb_async_fifo_param;

  // ---------------- default instance ----------------
  logic       wr_clk = 1'b0, rd_clk = 1'b0, reset;
  logic       wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       wr_full, wr_almost_full, wr_overflow;
  logic [3:0] wr_level, rd_level;
  logic       rd_valid, rd_empty, rd_almost_empty, rd_underflow;

  // ---------------- wide instance -------------------
  logic        w_wr_clk = 1'b0, w_rd_clk = 1'b0, w_reset;
  logic        w_wr_en, w_rd_en;
  logic [15:0] w_wr_data, w_rd_data;
  logic        w_wr_full, w_wr_almost_full, w_wr_overflow;
  logic [4:0]  w_wr_level, w_rd_level;
  logic        w_rd_valid, w_rd_empty, w_rd_almost_empty, w_rd_underflow;
  int          w_wr_half = 5, w_rd_half = 15;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] wexp_q[$];
  int          wide_rx = 0;

  async_fifo_param u_dut (
    .wr_clk(wr_clk), .reset(reset), .rd_clk(rd_clk),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .wr_almost_full(wr_almost_full), .wr_level(wr_level), .wr_overflow(wr_overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty), .rd_level(rd_level), .rd_underflow(rd_underflow)
  );

  async_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_dut_w (
    .wr_clk(w_wr_clk), .reset(w_reset), .rd_clk(w_rd_clk),
    .wr_en(w_wr_en), .wr_data(w_wr_data), .wr_full(w_wr_full),
    .wr_almost_full(w_wr_almost_full), .wr_level(w_wr_level), .wr_overflow(w_wr_overflow),
    .rd_en(w_rd_en), .rd_data(w_rd_data), .rd_valid(w_rd_valid), .rd_empty(w_rd_empty),
    .rd_almost_empty(w_rd_almost_empty), .rd_level(w_rd_level), .rd_underflow(w_rd_underflow)
  );

  // Clocks: 10 / 17 for the default instance, variable ratio for the wide one
  initial forever #5 wr_clk = ~wr_clk;
  initial forever begin #8 rd_clk = 1'b1; #9 rd_clk = 1'b0; end
  initial forever #(w_wr_half) w_wr_clk = ~w_wr_clk;
  initial forever #(w_rd_half) w_rd_clk = ~w_rd_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a write lands only if fewer than DEPTH words are outstanding
  task automatic wr_word(input logic [7:0] d);
    @(negedge wr_clk);
    wr_en = 1'b1;
    wr_data = d;
    if (exp_q.size() < 8) exp_q.push_back(d);
    @(negedge wr_clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_word();
    @(negedge rd_clk);
    rd_en = 1'b1;
    @(negedge rd_clk);
    rd_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_full"}, 32'(wr_full), 0);
    check({tag, "_wr_almost_full"}, 32'(wr_almost_full), 0);
    check({tag, "_wr_level"}, 32'(wr_level), 0);
    check({tag, "_wr_overflow"}, 32'(wr_overflow), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_rd_empty"}, 32'(rd_empty), 1);
    check({tag, "_rd_almost_empty"}, 32'(rd_almost_empty), 1);
    check({tag, "_rd_level"}, 32'(rd_level), 0);
    check({tag, "_rd_underflow"}, 32'(rd_underflow), 0);
  endtask

  // Random traffic on the wide instance until target words have been received
  task automatic run_wide_phase(input int target);
    int sent;
    sent = 0;
    fork
      begin
        while (sent < 100) begin
          @(negedge w_wr_clk);
          if (($urandom_range(0, 1) == 1) && !w_wr_full) begin
            w_wr_en = 1'b1;
            w_wr_data = 16'($urandom);
            wexp_q.push_back(w_wr_data);
            sent++;
          end else begin
            w_wr_en = 1'b0;
          end
        end
        @(negedge w_wr_clk);
        w_wr_en = 1'b0;
      end
      begin
        int guard;
        guard = 0;
        while (wide_rx < target && guard < 6000) begin
          @(negedge w_rd_clk);
          w_rd_en = ($urandom_range(0, 1) == 1) && !w_rd_empty;
          guard++;
        end
        w_rd_en = 1'b0;
      end
    join
    check("wide_words_received", 32'(wide_rx), 32'(target));
  endtask

  initial begin
    logic [7:0] saved;
    int n;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    w_reset = 1'b1; w_wr_en = 1'b0; w_rd_en = 1'b0; w_wr_data = '0;

    // Scoreboard monitors: pop expected word whenever a DUT presents rd_valid
    fork
      begin : mon_default
        logic [7:0] e;
        forever begin
          @(posedge rd_clk); #1;
          if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 0);
            else begin
              e = exp_q.pop_front();
              check("rd_data_order", 32'(rd_data), 32'(e));
            end
          end
        end
      end
      begin : mon_wide
        logic [15:0] e;
        forever begin
          @(posedge w_rd_clk); #1;
          if (w_rd_valid) begin
            if (wexp_q.size() == 0) check("wide_rd_valid_unexpected", 32'(w_rd_valid), 0);
            else begin
              e = wexp_q.pop_front();
              check("wide_rd_data_order", 32'(w_rd_data), 32'(e));
              wide_rx++;
            end
          end
        end
      end
    join_none

    // Power-on reset
    repeat (6) @(negedge rd_clk);
    @(negedge wr_clk);
    check_reset_values("por");
    reset = 1'b0;
    repeat (4) @(negedge rd_clk);

    // Fill to full
    for (int i = 1; i <= 8; i++) wr_word(8'(i));
    check("full_after_8", 32'(wr_full), 1);
    check("wr_level_8", 32'(wr_level), 8);
    check("wr_af_at_8", 32'(wr_almost_full), 1);

    // Writes at full are dropped and flagged
    wr_word(8'hAA);
    check("overflow_set", 32'(wr_overflow), 1);
    wr_word(8'hBB);
    check("wr_level_hold_8", 32'(wr_level), 8);
    repeat (3) @(negedge rd_clk);
    check("rd_level_8", 32'(rd_level), 8);

    // Drain: only 0x01..0x08 come out
    for (int i = 0; i < 8; i++) rd_word();
    repeat (2) @(negedge rd_clk);
    check("empty_after_drain", 32'(rd_empty), 1);
    check("drain_all_received", 32'(exp_q.size()), 0);
    repeat (6) @(negedge wr_clk);
    check("not_full_after_drain", 32'(wr_full), 0);
    check("overflow_sticky", 32'(wr_overflow), 1);

    // Reads while empty
    saved = rd_data;
    @(negedge rd_clk);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge rd_clk); #1;
      check("no_valid_when_empty", 32'(rd_valid), 0);
    end
    @(negedge rd_clk);
    rd_en = 1'b0;
    check("underflow_set", 32'(rd_underflow), 1);
    check("rd_data_unchanged", 32'(rd_data), 32'(saved));

    // Single write: empty-deassert latency through the synchroniser
    @(negedge wr_clk);
    wr_en = 1'b1;
    wr_data = 8'h5A;
    exp_q.push_back(8'h5A);
    @(posedge wr_clk);
    fork begin @(negedge wr_clk); wr_en = 1'b0; end join_none
    n = 0;
    while (rd_empty && n < 10) begin
      @(posedge rd_clk); #1;
      n++;
    end
    check("empty_latency_in_3_4", 32'((n >= 3) && (n <= 4)), 1);
    check("rd_level_1", 32'(rd_level), 1);
    check("rd_ae_at_1", 32'(rd_almost_empty), 1);
    for (int i = 0; i < 5; i++) wr_word(8'h5B + 8'(i));
    repeat (5) @(negedge rd_clk);
    check("rd_level_6", 32'(rd_level), 6);
    check("rd_ae_at_6", 32'(rd_almost_empty), 0);
    check("wr_level_6", 32'(wr_level), 6);
    check("wr_af_at_6", 32'(wr_almost_full), 1);
    for (int i = 0; i < 6; i++) rd_word();
    repeat (2) @(negedge rd_clk);
    check("second_drain_received", 32'(exp_q.size()), 0);

    // Reset mid-operation with 5 words stored; writes during reset ignored
    for (int i = 0; i < 5; i++) wr_word(8'hC0 + 8'(i));
    repeat (5) @(negedge rd_clk);
    check("rd_level_5_before_reset", 32'(rd_level), 5);
    @(negedge wr_clk);
    reset = 1'b1;
    exp_q.delete();
    wr_en = 1'b1;
    wr_data = 8'h77;
    repeat (4) @(negedge rd_clk);
    @(negedge wr_clk);
    wr_en = 1'b0;
    check_reset_values("midrst");
    reset = 1'b0;
    repeat (6) @(negedge rd_clk);
    check("no_overflow_after_reset", 32'(wr_overflow), 0);
    check("empty_after_reset", 32'(rd_empty), 1);
    wr_word(8'h33);
    repeat (6) @(negedge rd_clk);
    rd_word();
    repeat (2) @(negedge rd_clk);
    check("post_reset_word_received", 32'(exp_q.size()), 0);
    check("post_reset_empty", 32'(rd_empty), 1);

    // Wide instance: random traffic, writer fast then reader fast
    @(negedge w_wr_clk);
    w_reset = 1'b0;
    repeat (8) @(negedge w_rd_clk);
    run_wide_phase(100);
    w_wr_half = 15;
    w_rd_half = 5;
    repeat (4) @(negedge w_wr_clk);
    run_wide_phase(200);
    repeat (4) @(negedge w_rd_clk);
    check("wide_no_overflow", 32'(w_wr_overflow), 0);
    check("wide_no_underflow", 32'(w_rd_underflow), 0);
    check("wide_queue_empty", 32'(wexp_q.size()), 0);
    check("wide_rd_empty", 32'(w_rd_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
